kempston_mouse_accum: RTL and testbench

KEMPSTON_MOUSE_ACCUM -- requirements
Module: kempston_mouse_accum

---
 rtl/kempston_mouse_accum.sv | 138 +++++++++++++
 tb/tb_kempston_mouse_accum.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kempston_mouse_accum.sv
// PS/2 three-byte mouse packet decoder that accumulates wrapping 8-bit X/Y
// positions and button state, with byte-sync checking and mid-packet timeout.
module kempston_mouse_accum #(
  parameter int TIMEOUT        = 100000,
  parameter bit BTN_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       data_valid,
  input  logic [7:0] data,
  output logic [7:0] mouse_x,
  output logic [7:0] mouse_y,
  output logic [2:0] buttons,
  output logic       packet_strobe,
  output logic       sync_error
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX     = CW'(TIMEOUT - 1);
  localparam logic [2:0]    BTN_IDLE = BTN_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {BYTE1, BYTE2, BYTE3} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    dx_q, dx_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [2:0]    btn_q, btn_d;
  logic          pkt_q, pkt_d;
  logic          err_q, err_d;

  logic       strobe;
  logic       expire;
  logic [2:0] btn_new;

  assign strobe  = enable & data_valid;
  assign expire  = (cnt_q == TMAX);
  assign btn_new = BTN_ACTIVE_LOW ? ~status_q[2:0] : status_q[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BYTE1;
      cnt_q    <= '0;
      status_q <= '0;
      dx_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      btn_q    <= BTN_IDLE;
      pkt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      dx_q     <= dx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      btn_q    <= btn_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    dx_d     = dx_q;
    x_d      = x_q;
    y_d      = y_q;
    btn_d    = btn_q;
    pkt_d    = 1'b0;
    err_d    = 1'b0;
    if (!enable) begin
      // Host owns the bus: drop any partial packet silently.
      state_d = BYTE1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        BYTE1: begin
          cnt_d = '0;
          if (strobe) begin
            if (data[3]) begin
              status_d = data;
              state_d  = BYTE2;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        BYTE2: begin
          if (strobe) begin
            dx_d    = data;
            cnt_d   = '0;
            state_d = BYTE3;
          end else if (expire) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = BYTE1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BYTE3: begin
          if (strobe) begin
            // Sign bits are ignored: the low 8 bits of the delta wrap naturally.
            if (!status_q[6]) x_d = x_q + dx_q;
            if (!status_q[7]) y_d = y_q + data;
            btn_d   = btn_new;
            pkt_d   = 1'b1;
            cnt_d   = '0;
            state_d = BYTE1;
          end else if (expire) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = BYTE1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = BYTE1;
        end
      endcase
    end
  end

  assign mouse_x       = x_q;
  assign mouse_y       = y_q;
  assign buttons       = btn_q;
  assign packet_strobe = pkt_q;
  assign sync_error    = err_q;

endmodule

// File: tb/tb_kempston_mouse_accum.sv
// Bench for kempston_mouse_accum: directed packets plus random byte streams
// checked against a queue-based packet model.
module tb_kempston_mouse_accum;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst, enable, data_valid;
  logic [7:0] data;
  logic [7:0] mouse_x, mouse_y;
  logic [2:0] buttons;
  logic       packet_strobe, sync_error;

  kempston_mouse_accum #(.TIMEOUT(TO), .BTN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_valid(data_valid), .data(data),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .buttons(buttons),
    .packet_strobe(packet_strobe), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int pkt_cnt = 0, err_cnt = 0, both_cnt = 0;
  int exp_pkt = 0, exp_err = 0;
  logic [7:0] ex = 8'h00, ey = 8'h00;
  logic [2:0] ebtn = 3'b111;
  logic [7:0] pend[$];

  // Pulse counters sampled shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (packet_strobe) pkt_cnt++;
    if (sync_error) err_cnt++;
    if (packet_strobe && sync_error) both_cnt++;
  end

  // Packet model: a byte either starts, extends or completes the pending packet.
  task automatic model_byte(input logic [7:0] b);
    if (pend.size() == 0) begin
      if (b[3]) pend.push_back(b);
      else exp_err++;
    end else if (pend.size() == 1) begin
      pend.push_back(b);
    end else begin
      if (!pend[0][6]) ex = ex + pend[1];
      if (!pend[0][7]) ey = ey + b;
      ebtn = ~pend[0][2:0];
      exp_pkt++;
      pend.delete();
    end
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    if (enable) model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; data_valid = 1'b0; data = 8'h00;
    idle(3);
    rst = 1'b0;
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'h00, 8'h00, 3'b111}) begin
      miscompares++;
      $display("FAIL reset_out got %h/%h/%b want 00/00/111", mouse_x, mouse_y, buttons);
    end
    idle(2);
    vectors++;
    if ({pkt_cnt, err_cnt} !== {32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_pulses got pkt=%0d err=%0d want 0/0", pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_basic;
    send(8'h09); send(8'h05); send(8'h03);
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'h05, 8'h03, 3'b110}) begin
      miscompares++;
      $display("FAIL basic_out got %h/%h/%b want 05/03/110", mouse_x, mouse_y, buttons);
    end
    vectors++;
    if (pkt_cnt !== 1 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL basic_pulses got pkt=%0d err=%0d want 1/0", pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_wrap;
    send(8'h38); send(8'hFD); send(8'h00);
    vectors++;
    if ({mouse_x, mouse_y} !== {8'h02, 8'h03}) begin
      miscompares++;
      $display("FAIL neg_delta got %h/%h want 02/03", mouse_x, mouse_y);
    end
    send(8'h18); send(8'hFC); send(8'h00);
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'hFE, 8'h03, 3'b111}) begin
      miscompares++;
      $display("FAIL wrap_out got %h/%h/%b want FE/03/111", mouse_x, mouse_y, buttons);
    end
  endtask

  task automatic test_overflow;
    send(8'h48); send(8'h7F); send(8'h10);
    vectors++;
    if ({mouse_x, mouse_y} !== {8'hFE, 8'h13}) begin
      miscompares++;
      $display("FAIL x_overflow got %h/%h want FE/13", mouse_x, mouse_y);
    end
    send(8'h8C); send(8'h01); send(8'h40);
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'hFF, 8'h13, 3'b011}) begin
      miscompares++;
      $display("FAIL y_overflow got %h/%h/%b want FF/13/011", mouse_x, mouse_y, buttons);
    end
  endtask

  task automatic test_stray;
    int e0;
    e0 = err_cnt;
    send(8'h00);
    idle(1);
    vectors++;
    if (err_cnt !== e0 + 1 || {mouse_x, mouse_y} !== {8'hFF, 8'h13}) begin
      miscompares++;
      $display("FAIL stray got err=%0d xy=%h/%h want err=%0d xy=FF/13", err_cnt, mouse_x, mouse_y, e0 + 1);
    end
    send(8'h09); send(8'h01); send(8'h01);
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'h00, 8'h14, 3'b110}) begin
      miscompares++;
      $display("FAIL after_stray got %h/%h/%b want 00/14/110", mouse_x, mouse_y, buttons);
    end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    send(8'h08); send(8'h01);
    idle(TO - 1);
    vectors++;
    if (err_cnt !== e0) begin
      miscompares++;
      $display("FAIL early_timeout got err=%0d want %0d", err_cnt, e0);
    end
    idle(1);
    vectors++;
    if (err_cnt !== e0 + 1 || {mouse_x, mouse_y} !== {8'h00, 8'h14}) begin
      miscompares++;
      $display("FAIL timeout got err=%0d xy=%h/%h want err=%0d xy=00/14", err_cnt, mouse_x, mouse_y, e0 + 1);
    end
    pend.delete();
    exp_err++;
    send(8'h08); send(8'h02); send(8'h02);
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'h02, 8'h16, 3'b111}) begin
      miscompares++;
      $display("FAIL after_timeout got %h/%h/%b want 02/16/111", mouse_x, mouse_y, buttons);
    end
  endtask

  task automatic test_coincide;
    int e0;
    e0 = err_cnt;
    send(8'h08);
    idle(TO - 1);
    send(8'h03);
    idle(TO - 1);
    send(8'h04);
    vectors++;
    if (err_cnt !== e0 || {mouse_x, mouse_y} !== {8'h05, 8'h1A}) begin
      miscompares++;
      $display("FAIL coincide got err=%0d xy=%h/%h want err=%0d xy=05/1A", err_cnt, mouse_x, mouse_y, e0);
    end
  endtask

  task automatic test_enable;
    int e0, p0;
    send(8'h08); send(8'h01);
    e0 = err_cnt; p0 = pkt_cnt;
    enable = 1'b0;
    pend.delete();
    send(8'h05);
    idle(2);
    vectors++;
    if (err_cnt !== e0 || pkt_cnt !== p0 || {mouse_x, mouse_y} !== {8'h05, 8'h1A}) begin
      miscompares++;
      $display("FAIL disabled got err=%0d pkt=%0d xy=%h/%h want %0d/%0d 05/1A", err_cnt, pkt_cnt, mouse_x, mouse_y, e0, p0);
    end
    enable = 1'b1;
    send(8'h08); send(8'h01); send(8'h01);
    vectors++;
    if ({mouse_x, mouse_y} !== {8'h06, 8'h1B} || pkt_cnt !== p0 + 1) begin
      miscompares++;
      $display("FAIL reenable got %h/%h pkt=%0d want 06/1B pkt=%0d", mouse_x, mouse_y, pkt_cnt, p0 + 1);
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    int run;
    run = 0;
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if (!enable) begin
        pend.delete();
        run = 0;
      end
      if ($urandom_range(0, 3) != 0 || run >= 8) begin
        b = 8'($urandom);
        if (pend.size() == 0 && $urandom_range(0, 4) != 0) b[3] = 1'b1;
        send(b);
        run = 0;
      end else begin
        idle(1);
        run++;
      end
      vectors++;
      if ({mouse_x, mouse_y, buttons} !== {ex, ey, ebtn} || pkt_cnt !== exp_pkt || err_cnt !== exp_err) begin
        miscompares++;
        $display("FAIL random[%0d] got %h/%h/%b pkt=%0d err=%0d want %h/%h/%b pkt=%0d err=%0d",
                 i, mouse_x, mouse_y, buttons, pkt_cnt, err_cnt, ex, ey, ebtn, exp_pkt, exp_err);
      end
    end
    enable = 1'b1;
    pend.delete();
    idle(1);
  endtask

  task automatic test_reset_mid;
    send(8'h08); send(8'h05);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    pend.delete();
    ex = 8'h00; ey = 8'h00; ebtn = 3'b111;
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'h00, 8'h00, 3'b111}) begin
      miscompares++;
      $display("FAIL reset_mid got %h/%h/%b want 00/00/111", mouse_x, mouse_y, buttons);
    end
    send(8'h09); send(8'h01); send(8'h01);
    vectors++;
    if ({mouse_x, mouse_y, buttons} !== {8'h01, 8'h01, 3'b110}) begin
      miscompares++;
      $display("FAIL after_reset_mid got %h/%h/%b want 01/01/110", mouse_x, mouse_y, buttons);
    end
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL pulse_overlap got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_stray();
    test_timeout();
    test_coincide();
    test_enable();
    ex = mouse_x; ey = mouse_y; ebtn = buttons;
    exp_pkt = pkt_cnt; exp_err = err_cnt;
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
